// File: rtl/branch_predictor_if.sv
// Fetch/resolve/perf bundle between the pipeline and the branch predictor.
// slave = predictor side, master = pipeline side.
interface branch_predictor_if;
  logic [31:0] fetch_pc;
  logic        fetch_stall;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_pred_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispred_count;

  modport slave (
    input  fetch_pc, fetch_stall,
    input  update_valid, update_pc,
    input  update_taken, update_target,
    input  update_pred_taken,
    output pred_taken, pred_target,
    output mispredict, redirect_pc,
    output branch_count, mispred_count
  );

  modport master (
    output fetch_pc, fetch_stall,
    output update_valid, update_pc,
    output update_taken, update_target,
    output update_pred_taken,
    input  pred_taken, pred_target,
    input  mispredict, redirect_pc,
    input  branch_count, mispred_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, mispredict redirect and perf counts.
// Ports: clk_i, rst_i (sync, active-high), bp (branch_predictor_if.slave).
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input logic               clk_i,
  input logic               rst_i,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TLO = IDX_BITS + 2;
  localparam int THI = IDX_BITS + TAG_BITS + 1;

  logic                valid_q [ENTRIES];
  logic [1:0]          ctr_q   [ENTRIES];
  logic [TAG_BITS-1:0] tag_q   [ENTRIES];
  logic [31:0]         tgt_q   [ENTRIES];

  logic        ptaken_q, ptaken_d;
  logic [31:0] ptgt_q, ptgt_d;
  logic        mis_q, mis_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] bcnt_q, bcnt_d;
  logic [31:0] mcnt_q, mcnt_d;

  logic [IDX_BITS-1:0] f_idx, u_idx;
  logic [TAG_BITS-1:0] f_tag, u_tag;
  logic                f_hit, u_hit;

  logic                wr_en;
  logic [1:0]          wr_ctr;
  logic [31:0]         wr_tgt;

  assign f_idx = bp.fetch_pc[IDX_BITS+1:2];
  assign f_tag = bp.fetch_pc[THI:TLO];
  assign u_idx = bp.update_pc[IDX_BITS+1:2];
  assign u_tag = bp.update_pc[THI:TLO];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Lookup reads pre-update table contents; no bypass from the update port.
  always_comb begin
    ptaken_d = ptaken_q;
    ptgt_d   = ptgt_q;
    if (!bp.fetch_stall) begin
      ptaken_d = f_hit && ctr_q[f_idx][1];
      ptgt_d   = ptaken_d ? tgt_q[f_idx]
                          : bp.fetch_pc + 32'd4;
    end
  end

  always_comb begin
    wr_en  = 1'b0;
    wr_ctr = ctr_q[u_idx];
    wr_tgt = tgt_q[u_idx];
    unique case (1'b1)
      (bp.update_valid && u_hit && bp.update_taken): begin
        wr_en  = 1'b1;
        wr_ctr = (ctr_q[u_idx] == 2'b11) ? 2'b11
                                         : ctr_q[u_idx] + 2'b01;
        wr_tgt = bp.update_target;
      end
      (bp.update_valid && u_hit && !bp.update_taken): begin
        wr_en  = 1'b1;
        wr_ctr = (ctr_q[u_idx] == 2'b00) ? 2'b00
                                         : ctr_q[u_idx] - 2'b01;
      end
      (bp.update_valid && !u_hit && bp.update_taken): begin
        // Allocation overwrites whatever aliased into this slot.
        wr_en  = 1'b1;
        wr_ctr = 2'b10;
        wr_tgt = bp.update_target;
      end
      default: ;
    endcase
  end

  // Only direction is judged; a wrong target on a correct taken is not flagged.
  always_comb begin
    mis_d   = 1'b0;
    redir_d = redir_q;
    bcnt_d  = bcnt_q;
    mcnt_d  = mcnt_q;
    if (bp.update_valid) begin
      mis_d   = bp.update_taken != bp.update_pred_taken;
      redir_d = bp.update_taken ? bp.update_target
                                : bp.update_pc + 32'd4;
      if (bcnt_q != '1) bcnt_d = bcnt_q + 32'd1;
      if (mis_d && mcnt_q != '1) mcnt_d = mcnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
      ptaken_q <= 1'b0;
      ptgt_q   <= '0;
      mis_q    <= 1'b0;
      redir_q  <= '0;
      bcnt_q   <= '0;
      mcnt_q   <= '0;
    end else begin
      if (wr_en) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        ctr_q[u_idx]   <= wr_ctr;
        tgt_q[u_idx]   <= wr_tgt;
      end
      ptaken_q <= ptaken_d;
      ptgt_q   <= ptgt_d;
      mis_q    <= mis_d;
      redir_q  <= redir_d;
      bcnt_q   <= bcnt_d;
      mcnt_q   <= mcnt_d;
    end
  end

  assign bp.pred_taken    = ptaken_q;
  assign bp.pred_target   = ptgt_q;
  assign bp.mispredict    = mis_q;
  assign bp.redirect_pc   = redir_q;
  assign bp.branch_count  = bcnt_q;
  assign bp.mispred_count = mcnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor.
// Drives the interface after each edge, checks outputs #1 after the edge.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  branch_predictor_if bp();

  branch_predictor dut (
    .clk_i (clk),
    .rst_i (rst),
    .bp    (bp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc,
                     input logic t,
                     input logic [31:0] tgt,
                     input logic pt);
    bp.update_valid      = 1'b1;
    bp.update_pc         = pc;
    bp.update_taken      = t;
    bp.update_target     = tgt;
    bp.update_pred_taken = pt;
  endtask

  initial begin
    bp.fetch_pc = 32'h0;
    bp.fetch_stall = 1'b0;
    bp.update_valid = 1'b0;
    bp.update_pc = 32'h0;
    bp.update_taken = 1'b0;
    bp.update_target = 32'h0;
    bp.update_pred_taken = 1'b0;

    // reset state
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_ptaken", {31'b0, bp.pred_taken}, 32'h0);
    chk("rst_ptgt", bp.pred_target, 32'h0);
    chk("rst_mis", {31'b0, bp.mispredict}, 32'h0);
    chk("rst_redir", bp.redirect_pc, 32'h0);
    chk("rst_bcnt", bp.branch_count, 32'h0);
    chk("rst_mcnt", bp.mispred_count, 32'h0);

    // cold lookup
    bp.fetch_pc = 32'h0040_0010;
    tick();
    chk("cold_ptaken", {31'b0, bp.pred_taken}, 32'h0);
    chk("cold_ptgt", bp.pred_target, 32'h0040_0014);

    // allocate via mispredicted taken
    upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
    tick();
    bp.update_valid = 1'b0;
    chk("alloc_mis", {31'b0, bp.mispredict}, 32'h1);
    chk("alloc_redir", bp.redirect_pc, 32'h0040_0100);
    chk("alloc_mcnt", bp.mispred_count, 32'h1);
    chk("alloc_bcnt", bp.branch_count, 32'h1);
    chk("alloc_oldlk", {31'b0, bp.pred_taken}, 32'h0);
    tick();
    chk("hit_ptaken", {31'b0, bp.pred_taken}, 32'h1);
    chk("hit_ptgt", bp.pred_target, 32'h0040_0100);
    chk("pulse_end", {31'b0, bp.mispredict}, 32'h0);
    chk("redir_hold", bp.redirect_pc, 32'h0040_0100);

    // three not-taken: 10 -> 01 -> 00 -> 00
    upd(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1);
    tick();
    chk("nt1_mis", {31'b0, bp.mispredict}, 32'h1);
    chk("nt1_redir", bp.redirect_pc, 32'h0040_0014);
    chk("nt1_mcnt", bp.mispred_count, 32'h2);
    upd(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b0);
    tick();
    chk("nt2_mis", {31'b0, bp.mispredict}, 32'h0);
    tick();
    bp.update_valid = 1'b0;
    chk("nt3_mis", {31'b0, bp.mispredict}, 32'h0);
    chk("nt3_bcnt", bp.branch_count, 32'h4);
    chk("nt3_mcnt", bp.mispred_count, 32'h2);
    tick();
    chk("nt_ptaken", {31'b0, bp.pred_taken}, 32'h0);
    chk("nt_ptgt", bp.pred_target, 32'h0040_0014);
    // counter at 00: one taken -> 01, still predicts not-taken
    upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
    tick();
    bp.update_valid = 1'b0;
    tick();
    chk("sat0_ptaken", {31'b0, bp.pred_taken}, 32'h0);

    // alias: same index, different tag
    rst = 1'b1;
    tick();
    rst = 1'b0;
    upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
    tick();
    upd(32'h0040_1010, 1'b1, 32'h0040_1100, 1'b0);
    tick();
    bp.update_valid = 1'b0;
    bp.fetch_pc = 32'h0040_0010;
    tick();
    chk("alias_old_pt", {31'b0, bp.pred_taken}, 32'h0);
    chk("alias_old_tg", bp.pred_target, 32'h0040_0014);
    bp.fetch_pc = 32'h0040_1010;
    tick();
    chk("alias_new_pt", {31'b0, bp.pred_taken}, 32'h1);
    chk("alias_new_tg", bp.pred_target, 32'h0040_1100);
    chk("alias_bcnt", bp.branch_count, 32'h2);

    // same-cycle lookup and update, then stall across an update
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bp.fetch_pc = 32'h0040_0010;
    upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
    tick();
    bp.update_valid = 1'b0;
    chk("rw_same_pt", {31'b0, bp.pred_taken}, 32'h0);
    chk("rw_same_tg", bp.pred_target, 32'h0040_0014);
    tick();
    chk("rw_next_pt", {31'b0, bp.pred_taken}, 32'h1);
    chk("rw_next_tg", bp.pred_target, 32'h0040_0100);
    bp.fetch_stall = 1'b1;
    bp.fetch_pc = 32'h0040_1010;
    upd(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1);
    tick();
    bp.update_valid = 1'b0;
    chk("stall_pt", {31'b0, bp.pred_taken}, 32'h1);
    chk("stall_tg", bp.pred_target, 32'h0040_0100);
    chk("stall_bcnt", bp.branch_count, 32'h2);
    chk("stall_mis", {31'b0, bp.mispredict}, 32'h1);
    bp.fetch_stall = 1'b0;
    tick();
    chk("unstall_pt", {31'b0, bp.pred_taken}, 32'h0);
    chk("unstall_tg", bp.pred_target, 32'h0040_1014);

    // fall-through wraps modulo 2^32
    bp.fetch_pc = 32'hFFFF_FFFC;
    tick();
    chk("wrap_tg", bp.pred_target, 32'h0);

    // branch counter saturation
    force dut.bcnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.bcnt_q;
    upd(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b0);
    tick();
    chk("sat_b1", bp.branch_count, 32'hFFFF_FFFF);
    tick();
    chk("sat_b2", bp.branch_count, 32'hFFFF_FFFF);
    tick();
    chk("sat_b3", bp.branch_count, 32'hFFFF_FFFF);

    // reset wins over a same-cycle update: no allocation
    bp.fetch_pc = 32'h0040_0020;
    upd(32'h0040_0020, 1'b1, 32'h0040_0200, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bp.update_valid = 1'b0;
    chk("rmid_pt", {31'b0, bp.pred_taken}, 32'h0);
    chk("rmid_tg", bp.pred_target, 32'h0);
    chk("rmid_mis", {31'b0, bp.mispredict}, 32'h0);
    chk("rmid_redir", bp.redirect_pc, 32'h0);
    chk("rmid_bcnt", bp.branch_count, 32'h0);
    chk("rmid_mcnt", bp.mispred_count, 32'h0);
    tick();
    tick();
    chk("noalloc_pt", {31'b0, bp.pred_taken}, 32'h0);
    chk("noalloc_tg", bp.pred_target, 32'h0040_0024);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- It supplies a predicted direction and target to fetch, and it receives resolved branch outcomes from the execute-stage compare logic.
- From each resolved outcome it updates its tables, flags mispredictions and produces the corrected PC for the fetch redirect.
- It also keeps saturating branch and mispredict counters for performance reporting.

Parameters:
- IDX_BITS, 6, log2 of BTB entries (64 entries); index = PC[IDX_BITS+1:2].
- TAG_BITS, 8, stored tag width; tag = PC[IDX_BITS+TAG_BITS+1:IDX_BITS+2].

Ports:
- Clk  input  1  clock, all state updates on rising edge.
- Rst  input  1  synchronous active-high reset.
- FetchPC  input  32  PC of the instruction being fetched.
- FetchStall  input  1  when 1, the prediction registers hold.
- PredTaken  output  1  registered predicted direction for the FetchPC captured last cycle.
- PredTarget  output  32  registered predicted next PC.
- UpdateValid  input  1  a branch resolved this cycle.
- UpdatePC  input  32  PC of the resolved branch.
- UpdateTaken  input  1  resolved direction (compare result).
- UpdateTarget  input  32  resolved taken-target.
- UpdatePredTaken  input  1  direction that was predicted for this branch, carried down the pipeline.
- Mispredict  output  1  registered, 1-cycle pulse.
- RedirectPC  output  32  registered corrected PC, valid while Mispredict=1.
- BranchCount  output  32  resolved branches, saturating at 32'hFFFFFFFF.
- MispredCount  output  32  mispredictions, saturating at 32'hFFFFFFFF.

Behaviour:
- Reset (Rst=1 at a rising edge):
  - all valid bits cleared; counters set to 2'b01; tags and targets set to 0;
  - PredTaken=0, PredTarget=0, Mispredict=0, RedirectPC=0, BranchCount=0, MispredCount=0;
  - reset overrides stall and update in the same cycle;
  - an update presented in the reset cycle is dropped.
- Lookup (1-cycle latency):
  - hit = valid[idx] && tag[idx]==FetchPC tag field.
  - If FetchStall=0, at the edge: PredTaken <= hit && ctr[idx][1]; PredTarget <= (hit && ctr[idx][1]) ? target[idx] : FetchPC+4.
  - If FetchStall=1: PredTaken and PredTarget hold.
- Update (takes effect at the edge where UpdateValid=1):
  - Hit entry, taken: ctr saturating increment, max 2'b11; target[idx] <= UpdateTarget.
  - Hit entry, not taken: ctr saturating decrement, min 2'b00; target unchanged.
  - Miss, taken: allocate by overwriting the slot. valid=1, tag=UpdatePC tag field, target=UpdateTarget, ctr=2'b10.
  - Miss, not taken: no table change.
- Same-index read and write in one cycle:
  - Lookup uses pre-update (old) table contents; there is no forwarding.
  - The new value is visible to a lookup one cycle later.
- Mispredict output:
  - At the edge with UpdateValid=1: Mispredict <= (UpdateTaken != UpdatePredTaken); RedirectPC <= UpdateTaken ? UpdateTarget : UpdatePC+4.
  - With UpdateValid=0: Mispredict <= 0 and RedirectPC holds.
  - Mispredict is never held longer than one cycle per update.
  - Target mismatch with the correct direction is not flagged; direction only.
- Counters:
  - BranchCount += 1 per UpdateValid.
  - MispredCount += 1 per flagged mispredict.
  - Both hold at all-ones; they never wrap.
- FetchStall does not block updates or counters.
- All address arithmetic is modulo 2^32; FetchPC=32'hFFFFFFFC yields a fall-through of 0.

Test Plan:
- Reset, then FetchPC=0x00400010 -> next cycle PredTaken=0, PredTarget=0x00400014; all counts 0.
- Update PC=0x00400010, taken, target=0x00400100, predTaken=0 -> next cycle Mispredict=1, RedirectPC=0x00400100, MispredCount=1. Fetch 0x00400010 -> PredTaken=1, PredTarget=0x00400100.
- Same branch, three not-taken updates -> ctr goes 10→01→00→00 (saturates). Lookup gives PredTaken=0, PredTarget=0x00400014. Only the first not-taken update (predTaken=1) pulses Mispredict with RedirectPC=0x00400014.
- Alias: allocate 0x00400010, then a taken update at 0x00401010 (same index, different tag) -> lookup of 0x00400010 misses (PredTaken=0); 0x00401010 hits.
- Same-cycle lookup and update to one index after reset -> that cycle predicts not-taken; the following cycle predicts taken. FetchStall=1 across an update holds PredTaken/PredTarget unchanged while BranchCount still increments.
- Preload BranchCount to 32'hFFFFFFFE via forced updates, apply 3 updates -> stays 32'hFFFFFFFF. Assert Rst mid-stream with UpdateValid=1 -> all outputs 0 next cycle, and no allocation occurs.
